// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Drives inter-stage en/flush, PC enable/select, dmem timeout and stall count.
module pipe_hazard_ctrl #(
  parameter int REG_W  = 5,
  parameter int CNT_W  = 32,
  parameter int MEM_TO = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_valid,
  input  logic             ex_is_load,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_redirect,
  input  logic             ex_busy,
  input  logic             imem_ready,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             trap,
  output logic             pc_en,
  output logic [1:0]       pc_sel,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic             bus_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int WC_W = $clog2(MEM_TO + 1);
  localparam logic [WC_W-1:0] TO_MAX = WC_W'(MEM_TO);
  localparam logic [WC_W-1:0] TO_HIT = WC_W'(MEM_TO - 1);

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    TRAP_RECOV
  } state_t;

  typedef struct packed {
    logic en;
    logic flush;
  } stg_t;

  localparam stg_t PASS = '{en: 1'b1, flush: 1'b0};
  localparam stg_t HOLD = '{en: 1'b0, flush: 1'b0};
  localparam stg_t BUBB = '{en: 1'b0, flush: 1'b1};

  state_t          state;
  logic [WC_W-1:0] wait_cnt;

  logic trap_act;
  logic mem_stall;
  logic rs1_hit;
  logic rs2_hit;
  logic load_use;

  assign trap_act  = trap & (state != TRAP_RECOV);
  assign mem_stall = dmem_req & ~dmem_ready;
  assign rs1_hit   = id_uses_rs1 & (id_rs1 == ex_rd);
  assign rs2_hit   = id_uses_rs2 & (id_rs2 == ex_rd);
  assign load_use  = ex_valid & ex_is_load & (ex_rd != '0)
                   & (rs1_hit | rs2_hit);

  // One-hot winner of the priority chain
  logic r_trap;
  logic r_mem;
  logic r_busy;
  logic r_redir;
  logic r_lu;
  logic r_fetch;
  logic blk_mem;
  logic blk_busy;
  logic blk_redir;
  logic blk_lu;

  assign blk_mem   = trap_act;
  assign blk_busy  = blk_mem | mem_stall;
  assign blk_redir = blk_busy | ex_busy;
  assign blk_lu    = blk_redir | ex_redirect;

  assign r_trap  = trap_act;
  assign r_mem   = ~blk_mem & mem_stall;
  assign r_busy  = ~blk_busy & ex_busy;
  assign r_redir = ~blk_redir & ex_redirect;
  assign r_lu    = ~blk_lu & load_use;
  assign r_fetch = ~(blk_lu | load_use) & ~imem_ready;

  stg_t       s_if;
  stg_t       s_id;
  stg_t       s_ex;
  stg_t       s_wb;
  logic       pc_en_c;
  logic [1:0] pc_sel_c;

  always_comb begin
    s_if     = PASS;
    s_id     = PASS;
    s_ex     = PASS;
    s_wb     = PASS;
    pc_en_c  = 1'b1;
    pc_sel_c = 2'd0;
    unique case (1'b1)
      r_trap: begin
        s_if     = BUBB;
        s_id     = BUBB;
        s_ex     = BUBB;
        s_wb     = BUBB;
        pc_sel_c = 2'd2;
      end
      r_mem: begin
        s_if    = HOLD;
        s_id    = HOLD;
        s_ex    = HOLD;
        s_wb    = BUBB;
        pc_en_c = 1'b0;
      end
      r_busy: begin
        s_if    = HOLD;
        s_id    = HOLD;
        s_ex    = BUBB;
        pc_en_c = 1'b0;
      end
      r_redir: begin
        s_if     = BUBB;
        s_id     = BUBB;
        pc_sel_c = 2'd1;
      end
      r_lu: begin
        s_if    = HOLD;
        s_id    = BUBB;
        pc_en_c = 1'b0;
      end
      r_fetch: begin
        s_if    = BUBB;
        pc_en_c = 1'b0;
      end
      default: ;
    endcase
  end

  // Reset forces the safe drain pattern without waiting for a clock
  always_comb begin
    if (!rst_n) begin
      pc_en        = 1'b0;
      pc_sel       = 2'd0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      mem_wb_flush = 1'b1;
      bus_err      = 1'b0;
    end else begin
      pc_en        = pc_en_c;
      pc_sel       = pc_sel_c;
      if_id_en     = s_if.en;
      id_ex_en     = s_id.en;
      ex_mem_en    = s_ex.en;
      mem_wb_en    = s_wb.en;
      if_id_flush  = s_if.flush;
      id_ex_flush  = s_id.flush;
      ex_mem_flush = s_ex.flush;
      mem_wb_flush = s_wb.flush;
      bus_err      = r_mem & (wait_cnt == TO_HIT);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      unique case (1'b1)
        r_trap: begin
          state    <= TRAP_RECOV;
          wait_cnt <= '0;
        end
        r_mem: begin
          state <= MEM_WAIT;
          if (wait_cnt != TO_MAX)
            wait_cnt <= wait_cnt + WC_W'(1);
        end
        default: begin
          state    <= RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (!pc_en && (stall_cnt != '1))
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: table vectors, corner sequences,
// and random stimulus against a rule-level reference model.
module tb_pipe_hazard_ctrl;

  localparam int REG_W  = 5;
  localparam int CNT_W  = 8;
  localparam int MEM_TO = 4;
  localparam int SMAX   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [REG_W-1:0] id_rs1, id_rs2, ex_rd;
  logic             id_uses_rs1, id_uses_rs2;
  logic             ex_valid, ex_is_load, ex_redirect, ex_busy;
  logic             imem_ready, dmem_req, dmem_ready, trap;
  logic             pc_en, bus_err;
  logic [1:0]       pc_sel;
  logic             if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic             if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic [CNT_W-1:0] stall_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(
    .REG_W (REG_W),
    .CNT_W (CNT_W),
    .MEM_TO(MEM_TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_valid    (ex_valid),
    .ex_is_load  (ex_is_load),
    .ex_rd       (ex_rd),
    .ex_redirect (ex_redirect),
    .ex_busy     (ex_busy),
    .imem_ready  (imem_ready),
    .dmem_req    (dmem_req),
    .dmem_ready  (dmem_ready),
    .trap        (trap),
    .pc_en       (pc_en),
    .pc_sel      (pc_sel),
    .if_id_en    (if_id_en),
    .id_ex_en    (id_ex_en),
    .ex_mem_en   (ex_mem_en),
    .mem_wb_en   (mem_wb_en),
    .if_id_flush (if_id_flush),
    .id_ex_flush (id_ex_flush),
    .ex_mem_flush(ex_mem_flush),
    .mem_wb_flush(mem_wb_flush),
    .bus_err     (bus_err),
    .stall_cnt   (stall_cnt)
  );

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       exv;
    logic       exld;
    logic [4:0] rd;
    logic       redir;
    logic       busy;
    logic       imr;
    logic       dreq;
    logic       drdy;
    logic       trap;
  } in_t;

  // en/fl bit order: {if_id, id_ex, ex_mem, mem_wb}
  typedef struct packed {
    logic       pc_en;
    logic [1:0] pc_sel;
    logic [3:0] en;
    logic [3:0] fl;
    logic       be;
  } exp_t;

  typedef struct {
    in_t   v;
    exp_t  x;
    string name;
  } vec_t;

  int   checks = 0;
  int   failures = 0;
  bit   m_recov;
  int   m_wl;
  int   m_scnt;
  vec_t tq[$];

  function automatic in_t mk(int rs1, int rs2, int u1, int u2, int exv,
                             int exld, int rd, int redir, int busy,
                             int imr, int dreq, int drdy, int tr);
    in_t v;
    v.rs1 = 5'(rs1);    v.rs2 = 5'(rs2);
    v.u1 = 1'(u1);      v.u2 = 1'(u2);
    v.exv = 1'(exv);    v.exld = 1'(exld);
    v.rd = 5'(rd);      v.redir = 1'(redir);
    v.busy = 1'(busy);  v.imr = 1'(imr);
    v.dreq = 1'(dreq);  v.drdy = 1'(drdy);
    v.trap = 1'(tr);
    return v;
  endfunction

  function automatic exp_t ex(int pe, int ps, logic [3:0] en,
                              logic [3:0] fl, int be);
    exp_t r;
    r.pc_en = 1'(pe);
    r.pc_sel = 2'(ps);
    r.en = en;
    r.fl = fl;
    r.be = 1'(be);
    return r;
  endfunction

  // Reference: the six priority rules applied directly
  function automatic exp_t model(in_t v);
    exp_t r;
    bit   lu;
    r  = ex(1, 0, 4'b1111, 4'b0000, 0);
    lu = v.exv && v.exld && v.rd != 0 &&
         ((v.u1 && v.rs1 == v.rd) || (v.u2 && v.rs2 == v.rd));
    if (v.trap && !m_recov)
      r = ex(1, 2, 4'b0000, 4'b1111, 0);
    else if (v.dreq && !v.drdy)
      r = ex(0, 0, 4'b0000, 4'b0001, int'(m_wl + 1 == MEM_TO));
    else if (v.busy)
      r = ex(0, 0, 4'b0001, 4'b0010, 0);
    else if (v.redir)
      r = ex(1, 1, 4'b0011, 4'b1100, 0);
    else if (lu)
      r = ex(0, 0, 4'b0011, 4'b0100, 0);
    else if (!v.imr)
      r = ex(0, 0, 4'b0111, 4'b1000, 0);
    return r;
  endfunction

  task automatic drive(input in_t v);
    id_rs1 = v.rs1;       id_rs2 = v.rs2;
    id_uses_rs1 = v.u1;   id_uses_rs2 = v.u2;
    ex_valid = v.exv;     ex_is_load = v.exld;
    ex_rd = v.rd;         ex_redirect = v.redir;
    ex_busy = v.busy;     imem_ready = v.imr;
    dmem_req = v.dreq;    dmem_ready = v.drdy;
    trap = v.trap;
  endtask

  task automatic chk_out(input string nm, input exp_t w);
    exp_t g;
    g = {pc_en, pc_sel,
         if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
         if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
         bus_err};
    checks++;
    if (g !== w) begin
      failures++;
      $display("FAIL %s: got pc_en=%b pc_sel=%0d en=%b flush=%b bus_err=%b, want pc_en=%b pc_sel=%0d en=%b flush=%b bus_err=%b",
               nm, g.pc_en, g.pc_sel, g.en, g.fl, g.be,
               w.pc_en, w.pc_sel, w.en, w.fl, w.be);
    end
  endtask

  task automatic chk_cnt(input string nm, input int w);
    checks++;
    if (stall_cnt !== CNT_W'(w)) begin
      failures++;
      $display("FAIL %s: stall_cnt got %0d want %0d", nm, stall_cnt, w);
    end
  endtask

  // Starts and ends 1 time unit after a rising edge
  task automatic step(input in_t v, input string nm, input bit use_tab,
                      input exp_t tab);
    exp_t mx;
    drive(v);
    #4;
    mx = model(v);
    chk_out(nm, use_tab ? tab : mx);
    chk_cnt({nm, "_cnt"}, m_scnt);
    @(posedge clk);
    if (!mx.pc_en && m_scnt < SMAX) m_scnt++;
    if (v.trap && !m_recov) begin
      m_recov = 1'b1;
      m_wl = 0;
    end else begin
      m_recov = 1'b0;
      m_wl = (v.dreq && !v.drdy) ? m_wl + 1 : 0;
    end
    #1;
  endtask

  task automatic run(input in_t v, input string nm);
    step(v, nm, 1'b0, '0);
  endtask

  task automatic add(input in_t v, input exp_t x, input string nm);
    vec_t e;
    e.v = v;
    e.x = x;
    e.name = nm;
    tq.push_back(e);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    in_t  idle, st, v;
    exp_t pass_x, rst_x, lu_x, mw_x, busy_x, fetch_x, trap_x;
    int   s0;

    idle    = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    st      = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    pass_x  = ex(1, 0, 4'b1111, 4'b0000, 0);
    rst_x   = ex(0, 0, 4'b0000, 4'b1111, 0);
    lu_x    = ex(0, 0, 4'b0011, 4'b0100, 0);
    mw_x    = ex(0, 0, 4'b0000, 4'b0001, 0);
    busy_x  = ex(0, 0, 4'b0001, 4'b0010, 0);
    fetch_x = ex(0, 0, 4'b0111, 4'b1000, 0);
    trap_x  = ex(1, 2, 4'b0000, 4'b1111, 0);

    add(idle, pass_x, "idle");
    add(mk(5, 0, 1, 0, 1, 1, 5, 0, 0, 1, 0, 0, 0), lu_x, "lu_rs1");
    add(mk(0, 0, 1, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0), pass_x, "lu_rd0");
    add(mk(3, 9, 0, 1, 1, 1, 9, 0, 0, 1, 0, 0, 0), lu_x, "lu_rs2");
    add(mk(3, 9, 1, 0, 1, 1, 9, 0, 0, 1, 0, 0, 0), pass_x, "rs2_unused");
    add(mk(5, 0, 1, 0, 0, 1, 5, 0, 0, 1, 0, 0, 0), pass_x, "ex_invalid");
    add(mk(5, 0, 1, 0, 1, 0, 5, 0, 0, 1, 0, 0, 0), pass_x, "not_load");
    add(mk(5, 0, 1, 0, 1, 1, 5, 1, 0, 1, 0, 0, 0),
        ex(1, 1, 4'b0011, 4'b1100, 0), "redir_over_lu");
    add(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), busy_x, "busy_nofetch");
    add(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), fetch_x, "fetch_stall");
    add(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0), mw_x, "mem_over_busy");
    add(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0), busy_x, "mem_done_busy");
    add(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 1), trap_x, "trap_over_all");
    add(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0),
        ex(1, 1, 4'b0011, 4'b1100, 0), "redir_nofetch");
    add(mk(7, 0, 1, 0, 1, 1, 7, 0, 0, 0, 0, 0, 0), lu_x, "lu_nofetch");

    // Power-on reset
    rst_n = 1'b0;
    drive(idle);
    m_recov = 1'b0;
    m_wl = 0;
    m_scnt = 0;
    #2;
    chk_out("reset", rst_x);
    chk_cnt("reset_cnt", 0);
    #6 rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (tq[i]) begin
      step(tq[i].v, tq[i].name, 1'b1, tq[i].x);
      run(idle, {tq[i].name, "_gap"});
    end

    // Load-use bubble then clean cycle
    s0 = m_scnt;
    step(mk(5, 0, 1, 0, 1, 1, 5, 0, 0, 1, 0, 0, 0), "seq_lu", 1'b1, lu_x);
    step(idle, "seq_lu_next", 1'b1, pass_x);
    chk_cnt("seq_lu_cnt", s0 + 1);

    // Redirect with load-use hazard: no stall cycle counted
    s0 = m_scnt;
    step(mk(5, 0, 1, 0, 1, 1, 5, 1, 0, 1, 0, 0, 0), "seq_redir", 1'b1,
         ex(1, 1, 4'b0011, 4'b1100, 0));
    step(idle, "seq_redir_next", 1'b1, pass_x);
    chk_cnt("seq_redir_cnt", s0);

    // Three dmem wait cycles, ready on the fourth
    s0 = m_scnt;
    for (int k = 0; k < 3; k++) step(st, "seq_mw", 1'b1, mw_x);
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0), "seq_mw_done",
         1'b1, pass_x);
    chk_cnt("seq_mw_cnt", s0 + 3);

    // Timeout: single bus_err pulse on 4th wait cycle
    for (int k = 1; k <= 6; k++)
      step(st, "seq_to", 1'b1, ex(0, 0, 4'b0000, 4'b0001, int'(k == 4)));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1), "seq_to_trap",
         1'b1, trap_x);
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1), "seq_recov_ign",
         1'b1, pass_x);
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1), "seq_trap_again",
         1'b1, trap_x);
    step(idle, "seq_trap_idle", 1'b1, pass_x);

    // Busy outranks fetch stall
    for (int k = 0; k < 5; k++)
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), "seq_busy",
           1'b1, busy_x);
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "seq_busy_rel",
         1'b1, fetch_x);
    step(idle, "seq_busy_idle", 1'b1, pass_x);

    // Async reset mid wait, while bus_err would pulse
    for (int k = 0; k < 3; k++) step(st, "seq_rst_mw", 1'b1, mw_x);
    drive(st);
    #2;
    chk_out("pre_rst_pulse", ex(0, 0, 4'b0000, 4'b0001, 1));
    rst_n = 1'b0;
    #1;
    chk_out("rst_mid", rst_x);
    chk_cnt("rst_mid_cnt", 0);
    m_recov = 1'b0;
    m_wl = 0;
    m_scnt = 0;
    drive(idle);
    #1 rst_n = 1'b1;
    #1;
    chk_out("rst_release", pass_x);
    @(posedge clk);
    #1;
    step(idle, "post_rst", 1'b1, pass_x);
    step(st, "post_rst_mw", 1'b1, mw_x);
    step(idle, "post_rst_idle", 1'b1, pass_x);

    // Random stimulus against the model
    for (int n = 0; n < 400; n++) begin
      v.rs1   = 5'($urandom_range(0, 3));
      v.rs2   = 5'($urandom_range(0, 3));
      v.u1    = 1'($urandom_range(0, 1));
      v.u2    = 1'($urandom_range(0, 1));
      v.exv   = 1'($urandom_range(0, 3) != 0);
      v.exld  = 1'($urandom_range(0, 1));
      v.rd    = 5'($urandom_range(0, 3));
      v.redir = 1'($urandom_range(0, 99) < 15);
      v.busy  = 1'($urandom_range(0, 99) < 15);
      v.imr   = 1'($urandom_range(0, 99) < 80);
      v.dreq  = 1'($urandom_range(0, 99) < 35);
      v.drdy  = 1'($urandom_range(0, 99) < 40);
      v.trap  = 1'($urandom_range(0, 99) < 6);
      run(v, "rand");
    end

    // Counter saturation
    for (int k = 0; k < SMAX + 5; k++)
      run(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "sat");
    chk_cnt("stall_sat", SMAX);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
